sram_controller: RTL and testbench

Memory-stage responder for the load/store requests that the decode stage issues down the pipeline as memory read and write enables. It serves each 32-bit word access as two consecutive 16-bit accesses to an external asynchronous SRAM with programmable wait states. While an access is in progress it holds `ready` low, and the top level uses that to freeze all pipeline registers.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_controller_if.sv | 30 +++
 rtl/sram_wait_counter.sv | 41 ++++
 rtl/sram_controller.sv | 123 ++++++++++++
 tb/tb_sram_controller.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// sram_pkg
//   Definitions shared by the SRAM memory-stage controller files:
//   FSM state encoding, the default data-space base address, SRAM data width
//   and a helper that sizes the wait-state counter.
//   No ports.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no access in progress
    LOW  = 2'd1,  // driving the low halfword
    HIGH = 2'd2,  // driving the high halfword
    DONE = 2'd3   // completion cycle, ready high
  } state_e;

  localparam logic [31:0] SRAM_BASE_ADDR_DEFAULT = 32'd1024;
  localparam int unsigned SRAM_DW                = 16;

  // ceil(log2(w)) bits, but never less than one so W=1 still has a register
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if
//   Memory-stage request/response bundle between the pipeline and the SRAM
//   controller.
//   Signals:
//     rd_en, wr_en  word read / write request
//     address       byte address (word aligned)
//     write_data    store data
//     read_data     registered load data
//     ready         low while an access is pending (pipeline freeze)
//   Modports: master = pipeline side, slave = controller side.
interface sram_controller_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
//   Wait-state counter for one SRAM halfword phase. Counts 0..WAIT_CYCLES-1
//   and flags the final cycle.
//   Ports:
//     clk     clock, rising edge
//     rst_n   asynchronous active-low reset
//     clr_i   force the count back to 0 on the next edge
//     last_o  count equals WAIT_CYCLES-1
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic last_o
);

  localparam int unsigned   CW       = cnt_width(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The owner clears on the last cycle of a phase, so the count never wraps.
  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/sram_controller.sv
// sram_controller
//   Serves 32-bit load/store requests from the memory stage as two 16-bit
//   accesses (low halfword, then high) to an asynchronous SRAM, each held for
//   WAIT_CYCLES cycles. ready is low while an access is pending.
//   Ports:
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     bus           request/response bundle (slave side)
//     sram_addr     SRAM halfword address
//     sram_dq_out   write data to the pad
//     sram_dq_oe    pad output enable
//     sram_dq_in    read data from the pad
//     sram_we_n     SRAM write strobe, active low
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_controller_if.slave     bus,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_we_n
);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        is_wr_q;
  logic [31:0] rdata_q;
  logic        ready;
  logic        req;
  logic        last;
  logic        cnt_clr;
  logic        in_access;
  logic        is_high;
  logic [31:0] offset;

  assign req       = bus.rd_en | bus.wr_en;
  assign in_access = (state_q == LOW) || (state_q == HIGH);
  assign is_high   = (state_q == HIGH);

  // Counter restarts at 0 on entry to LOW and again on entry to HIGH.
  assign cnt_clr = ~in_access | last;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) state_d = LOW;
      end
      LOW:     if (last) state_d = HIGH;
      HIGH:    if (last) state_d = DONE;
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Simultaneous rd_en/wr_en is illegal; treat it as a write.
      if (state_q == IDLE && req) begin
        addr_q  <= bus.address;
        wdata_q <= bus.write_data;
        is_wr_q <= bus.wr_en;
      end
      // Sample the pad on the final wait cycle of each read phase.
      if (in_access && !is_wr_q && last) begin
        if (is_high) rdata_q[31:16] <= sram_dq_in;
        else         rdata_q[15:0]  <= sram_dq_in;
      end
    end
  end

  assign bus.ready     = ready;
  assign bus.read_data = rdata_q;

  // Pins come only from registered state and latched request, so an async
  // reset drops the write strobe immediately. The halfword address wraps by
  // truncation, with no range check.
  assign offset = addr_q - BASE_ADDR;

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (in_access) begin
      sram_addr = SRAM_AW'({offset[31:2], is_high});
      if (is_wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        sram_dq_out = is_high ? wdata_q[31:16] : wdata_q[15:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Directed bench for sram_controller: one instance with WAIT_CYCLES=2 (A)
//   and one with WAIT_CYCLES=1 (B), each attached to a small SRAM model.
//   Expected load data is pushed to a scoreboard queue when a read is issued
//   and popped when the controller signals completion.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  sram_controller_if bus_a ();
  sram_controller_if bus_b ();

  logic [17:0] a_addr,   b_addr;
  logic [15:0] a_dq_out, b_dq_out;
  logic [15:0] a_dq_in,  b_dq_in;
  logic        a_oe,     b_oe;
  logic        a_we_n,   b_we_n;

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2), .SRAM_AW(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a),
    .sram_addr(a_addr), .sram_dq_out(a_dq_out), .sram_dq_oe(a_oe),
    .sram_dq_in(a_dq_in), .sram_we_n(a_we_n)
  );

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b),
    .sram_addr(b_addr), .sram_dq_out(b_dq_out), .sram_dq_oe(b_oe),
    .sram_dq_in(b_dq_in), .sram_we_n(b_we_n)
  );

  // Asynchronous-read SRAM models, write on the strobe
  logic [15:0] mem_a [0:63];
  logic [15:0] mem_b [0:63];
  always @(posedge clk) if (!a_we_n) mem_a[a_addr[5:0]] <= a_dq_out;
  always @(posedge clk) if (!b_we_n) mem_b[b_addr[5:0]] <= b_dq_out;
  assign a_dq_in = mem_a[a_addr[5:0]];
  assign b_dq_in = mem_b[b_addr[5:0]];

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] shadow_a [logic [31:0]];
  logic [31:0] shadow_b [logic [31:0]];
  logic [31:0] hold_rd  [2];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // k: 0 ready, 1 sram_addr, 2 we_n, 3 dq_oe, 4 dq_out, 5 read_data
  function automatic logic [31:0] obs(input bit b, input int k);
    case (k)
      0:       return b ? 32'(bus_b.ready) : 32'(bus_a.ready);
      1:       return b ? 32'(b_addr)      : 32'(a_addr);
      2:       return b ? 32'(b_we_n)      : 32'(a_we_n);
      3:       return b ? 32'(b_oe)        : 32'(a_oe);
      4:       return b ? 32'(b_dq_out)    : 32'(a_dq_out);
      default: return b ? bus_b.read_data  : bus_a.read_data;
    endcase
  endfunction

  task automatic drive(input bit b, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (b) begin
      bus_b.rd_en = rd; bus_b.wr_en = wr; bus_b.address = addr; bus_b.write_data = data;
    end else begin
      bus_a.rd_en = rd; bus_a.wr_en = wr; bus_a.address = addr; bus_a.write_data = data;
    end
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the access.
  // Returns just after the edge ending DONE with the request dropped.
  task automatic access(input bit b, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int          w;
    logic [31:0] tmp;
    logic [17:0] base;
    logic [31:0] e;
    logic        half;
    string       nm;
    w    = b ? 1 : 2;
    tmp  = ((addr - 32'd1024) >> 2) << 1;
    base = tmp[17:0];
    nm   = $sformatf("%s_%s_%h", b ? "B" : "A", wr ? "wr" : "rd", addr);
    if (wr) begin
      if (b) shadow_b[addr] = data; else shadow_a[addr] = data;
    end else begin
      exp_q.push_back(b ? shadow_b[addr] : shadow_a[addr]);
    end
    drive(b, !wr, wr, addr, data);
    for (int c = 0; c <= 2 * w + 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s ready c%0d", nm, c), obs(b, 0), 32'(c == 2 * w + 1));
      if (c >= 1 && c <= 2 * w) begin
        half = (c > w);
        chk($sformatf("%s addr c%0d", nm, c), obs(b, 1), 32'(base) + 32'(half));
        chk($sformatf("%s we_n c%0d", nm, c), obs(b, 2), 32'(!wr));
        chk($sformatf("%s oe c%0d",   nm, c), obs(b, 3), 32'(wr));
        if (wr)
          chk($sformatf("%s dq_out c%0d", nm, c), obs(b, 4),
              half ? 32'(data[31:16]) : 32'(data[15:0]));
      end
      if (c == 2 * w + 1) begin
        if (wr) begin
          chk($sformatf("%s rdata_hold", nm), obs(b, 5), hold_rd[b]);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s rdata", nm), obs(b, 5), e);
          hold_rd[b] = e;
        end
      end
    end
    @(posedge clk);
    #1;
    drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
    $display("txn %s done", nm);
  endtask

  initial begin
    hold_rd[0] = '0;
    hold_rd[1] = '0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    repeat (2) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("rst%0d ready", b), obs(b[0], 0), 32'd1);
      chk($sformatf("rst%0d addr",  b), obs(b[0], 1), 32'd0);
      chk($sformatf("rst%0d we_n",  b), obs(b[0], 2), 32'd1);
      chk($sformatf("rst%0d oe",    b), obs(b[0], 3), 32'd0);
      chk($sformatf("rst%0d dqout", b), obs(b[0], 4), 32'd0);
      chk($sformatf("rst%0d rdata", b), obs(b[0], 5), 32'd0);
    end
    rst_n = 1'b1;

    // Idle: 20 cycles without a request
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d ready", i), obs(1'b0, 0), 32'd1);
      chk($sformatf("idle%0d we_n",  i), obs(1'b0, 2), 32'd1);
      chk($sformatf("idle%0d oe",    i), obs(1'b0, 3), 32'd0);
      chk($sformatf("idle%0d addr",  i), obs(1'b0, 1), 32'd0);
      chk($sformatf("idle%0d dqout", i), obs(1'b0, 4), 32'd0);
    end
    $display("txn idle done");

    // Write, read-back, then back-to-back write/read
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'd1024, 32'h0);
    access(1'b0, 1'b1, 32'd1028, 32'h12345678);
    access(1'b0, 1'b0, 32'd1028, 32'h0);

    // Reset during the second LOW cycle of a write
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    chk("midrst pre we_n", obs(1'b0, 2), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst we_n",  obs(1'b0, 2), 32'd1);
    chk("midrst oe",    obs(1'b0, 3), 32'd0);
    chk("midrst addr",  obs(1'b0, 1), 32'd0);
    chk("midrst rdata", obs(1'b0, 5), 32'd0);
    chk("midrst ready_req", obs(1'b0, 0), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("midrst ready_noreq", obs(1'b0, 0), 32'd1);
    hold_rd[0] = '0;
    hold_rd[1] = '0;
    @(negedge clk);
    chk("midrst held we_n", obs(1'b0, 2), 32'd1);
    #1 rst_n = 1'b1;
    #1 drive(1'b0, 1'b1, 1'b0, 32'd1024, 32'd0);
    #1;
    chk("postrst ready_req", obs(1'b0, 0), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("postrst ready_noreq", obs(1'b0, 0), 32'd1);
    $display("txn reset_mid_write done");

    // Data written before the reset is still in the SRAM
    @(posedge clk);
    #1;
    access(1'b0, 1'b0, 32'd1024, 32'h0);

    // WAIT_CYCLES=1, including an address below BASE_ADDR that wraps
    access(1'b1, 1'b1, 32'd1020, 32'hA5A55A5A);
    access(1'b1, 1'b0, 32'd1020, 32'h0);
    access(1'b1, 1'b1, 32'd1032, 32'h0BADCAFE);
    access(1'b1, 1'b0, 32'd1032, 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
